jk_cmd_sequencer: RTL

- Upstream driver for the master-slave JK flip-flop stage: accepts HOLD/RESET/SET/TOGGLE commands on a valid/ready handshake and converts each into timed s/r drive levels.
- Reads the flop's qn/qn_bar back through a synchroniser, checks the result against the expected value, and reports done/error per command.
- Keeps saturating command and error counters for bench/debug readout.

---
 rtl/jk_pkg.sv | 48 ++++
 rtl/jk_cmd_sequencer_sync_chain.sv | 30 +++
 rtl/jk_cmd_sequencer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/jk_pkg.sv
// Shared command/state encodings and helpers for the JK flip-flop command sequencer.
package jk_pkg;

    typedef enum logic [1:0] {
        CMD_HOLD   = 2'b00,
        CMD_RESET  = 2'b01,
        CMD_SET    = 2'b10,
        CMD_TOGGLE = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_WAIT,
        ST_RESP
    } state_e;

    typedef struct packed {
        logic s;
        logic r;
    } sr_t;

    function automatic sr_t cmd_to_sr(input cmd_e c);
        sr_t sr;
        case (c)
            CMD_HOLD:   sr = '{s: 1'b0, r: 1'b0};
            CMD_RESET:  sr = '{s: 1'b0, r: 1'b1};
            CMD_SET:    sr = '{s: 1'b1, r: 1'b0};
            CMD_TOGGLE: sr = '{s: 1'b1, r: 1'b1};
            default:    sr = '{s: 1'b0, r: 1'b0};
        endcase
        return sr;
    endfunction

    // Q the flop should settle to once the command has been applied to current Q.
    function automatic logic cmd_exp_q(input cmd_e c, input logic q);
        logic e;
        case (c)
            CMD_HOLD:   e = q;
            CMD_RESET:  e = 1'b0;
            CMD_SET:    e = 1'b1;
            CMD_TOGGLE: e = ~q;
            default:    e = q;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/jk_cmd_sequencer_sync_chain.sv
// Multi-bit flop chain bringing asynchronous feedback into the clk domain.
module sync_chain #(
    parameter int STAGES = 2,
    parameter int WIDTH  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [STAGES];

    // NOTE: every stage is reset so a stale value can never look like valid feedback after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/jk_cmd_sequencer.sv
// Turns HOLD/RESET/SET/TOGGLE commands into timed s/r drive for a master-slave JK
// flop, verifies the synchronised Q/Q_bar feedback and keeps saturating counters.
module jk_cmd_sequencer
    import jk_pkg::*;
#(
    parameter int DRIVE_CYCLES = 2,
    parameter int TIMEOUT      = 8,
    parameter int SYNC_STAGES  = 2,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd,
    output logic             cmd_ready,
    output logic             s,
    output logic             r,
    input  logic             qn,
    input  logic             qn_bar,
    output logic             done,
    output logic             err,
    output logic             exp_q,
    output logic [CNT_W-1:0] cmd_count,
    output logic [CNT_W-1:0] err_count
);

    localparam int DW = $clog2(DRIVE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e           state_q;
    cmd_e             cmd_q;
    logic             ready_q, s_q, r_q, done_q, err_q, exp_q_q;
    logic [DW-1:0]    drv_cnt_q;
    logic [TW-1:0]    tmo_cnt_q;
    logic [CNT_W-1:0] cmd_count_q, err_count_q;

    logic             q_s, qb_s;
    cmd_e             cmd_in;
    logic             fb_match, fb_illegal, tmo_hit, resp_go_d, resp_err_d;
    logic [CNT_W-1:0] cmd_count_d, err_count_d;
    sr_t              sr_accept, sr_held;

    sync_chain #(
        .STAGES (SYNC_STAGES),
        .WIDTH  (2)
    ) u_fb_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   ({qn, qn_bar}),
        .q_o   ({q_s, qb_s})
    );

    assign cmd_in    = cmd_e'(cmd);
    assign sr_accept = cmd_to_sr(cmd_in);
    assign sr_held   = cmd_to_sr(cmd_q);

    always_comb begin
        fb_match    = (q_s == exp_q_q) && (qb_s == ~exp_q_q);
        fb_illegal  = (q_s == qb_s);
        tmo_hit     = (tmo_cnt_q == TW'(TIMEOUT - 1));
        // A match takes priority over both the illegal check and the timeout.
        resp_go_d   = fb_match || fb_illegal || tmo_hit;
        resp_err_d  = !fb_match;
        cmd_count_d = (cmd_count_q == CNT_MAX) ? cmd_count_q : cmd_count_q + CNT_W'(1);
        err_count_d = (resp_err_d && err_count_q != CNT_MAX) ? err_count_q + CNT_W'(1)
                                                              : err_count_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cmd_q       <= CMD_HOLD;
            ready_q     <= 1'b0;
            s_q         <= 1'b0;
            r_q         <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            exp_q_q     <= 1'b0;
            drv_cnt_q   <= '0;
            tmo_cnt_q   <= '0;
            cmd_count_q <= '0;
            err_count_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (ready_q && cmd_valid) begin
                        cmd_q     <= cmd_in;
                        exp_q_q   <= cmd_exp_q(cmd_in, q_s);
                        s_q       <= sr_accept.s;
                        r_q       <= sr_accept.r;
                        drv_cnt_q <= DW'(DRIVE_CYCLES);
                        ready_q   <= 1'b0;
                        state_q   <= ST_DRIVE;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                ST_DRIVE: begin
                    if (drv_cnt_q == DW'(1)) begin
                        s_q       <= 1'b0;
                        r_q       <= 1'b0;
                        tmo_cnt_q <= '0;
                        state_q   <= ST_WAIT;
                    end else begin
                        s_q       <= sr_held.s;
                        r_q       <= sr_held.r;
                        drv_cnt_q <= drv_cnt_q - DW'(1);
                    end
                end
                ST_WAIT: begin
                    if (resp_go_d) begin
                        done_q      <= 1'b1;
                        err_q       <= resp_err_d;
                        cmd_count_q <= cmd_count_d;
                        err_count_q <= err_count_d;
                        state_q     <= ST_RESP;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + TW'(1);
                    end
                end
                ST_RESP: begin
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = ready_q;
    assign s         = s_q;
    assign r         = r_q;
    assign done      = done_q;
    assign err       = err_q;
    assign exp_q     = exp_q_q;
    assign cmd_count = cmd_count_q;
    assign err_count = err_count_q;

endmodule
